if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: FIFO_DEPTH, 2, output buffer entries; only the value 2 is supported.
REQ-003 SHALL have port: clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port: rst  in  1  reset; asynchronous assert, active-high; one clock, async active-high reset.
REQ-005 SHALL have port: redirect  in  1  branch/jump/exception redirect from execute.
REQ-006 SHALL have port: redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-007 SHALL have port: irom_en  out  1  instruction ROM read request.
REQ-008 SHALL have port: irom_addr  out  32  byte address of the request.
REQ-009 SHALL have port: irom_rdata  in  32  ROM data, valid exactly 1 cycle after irom_en.
REQ-010 SHALL have port: if_valid  out  1  fetched instruction available to decode.
REQ-011 SHALL have port: id_ready  in  1  decode accepts; handshake = if_valid & id_ready.
REQ-012 SHALL have port: if_pc  out  32  address of if_inst.
REQ-013 SHALL have port: if_inst  out  32  instruction word.

Function
REQ-014 SHALL keep fetch PC register; after each issued request, PC <= PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-015 SHALL assert irom_en with irom_addr=PC only when (fifo_count + inflight - pop) < 2; never overflow the FIFO.
REQ-016 SHALL write {request pc, irom_rdata} into the FIFO on the cycle the response returns, unless killed.
REQ-017 SHALL present the FIFO head on if_pc/if_inst with if_valid=1 whenever the FIFO is non-empty; these outputs SHALL stay stable while if_valid & !id_ready.
REQ-018 SHALL pop the head on handshake; push and pop in the same cycle SHALL leave the count unchanged.
REQ-019 SHALL sustain 1 instruction/cycle when id_ready is held high; latency is 2 cycles from request to if_valid.
REQ-020 On redirect, SHALL flush the FIFO, kill any in-flight response, suppress irom_en that cycle, and load PC <= {redirect_pc[31:2],2'b00}.
REQ-021 SHALL issue the redirect target in cycle N+1, and if_valid for it SHALL rise in cycle N+3.
REQ-022 Redirect in the same cycle as a handshake: the handshake completes, then the flush applies; redirect has priority over all pushes.
REQ-023 Back-to-back redirects: only the last target is fetched.

Reset
REQ-024 While rst=1: PC=RESET_PC, FIFO empty, inflight=0, if_valid=0, irom_en=0, if_pc=0, if_inst=0.
REQ-025 rst asserted mid-operation SHALL discard all buffered and in-flight data immediately.
REQ-026 The first irom_en SHALL assert in the first cycle after rst deasserts, with irom_addr=RESET_PC.

Configuration
REQ-027 With macro AURORA_IF_PERF_CNT_EN defined, SHALL add output if_perf_fetch_cnt[31:0] and output if_perf_flush_cnt[31:0].
REQ-028 if_perf_fetch_cnt SHALL increment per handshake; if_perf_flush_cnt SHALL increment per redirect cycle.
REQ-029 Both counters SHALL reset to 0 and wrap at 2^32.
REQ-030 With AURORA_IF_PERF_CNT_EN undefined, the ports and logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-031 Shared package aurora_pkg SHALL hold XLEN=32, the default RESET_PC, the instruction width, and the NOP encoding 32'h0000_0013.
REQ-032 The 2-entry buffer SHALL be sub-module if_skid_fifo (push/pop/flush, count, head data); PC, issue and kill logic stay in if_stage.

Verification
REQ-033 Reset release, ROM word0=0x00000013, word1=0x00100093, id_ready=1 -> if_valid rises 2 cycles after release; pc 0x0 then 0x4 on consecutive cycles.
REQ-034 Stall: id_ready=0 for 5 cycles -> at most 2 buffered; irom_en low once full; outputs stable; after release, no skipped or duplicated pc.
REQ-035 Redirect to 0x0000_0103 while FIFO is full -> irom_addr=0x100 next cycle; if_valid with pc 0x100 at N+3; no stale pc is emitted.
REQ-036 Redirect concurrent with handshake of pc 0x8 -> pc 0x8 is consumed once; next output is the target.
REQ-037 Redirect to 0xFFFF_FFFC with id_ready=1 -> sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
REQ-038 rst pulsed mid-stream, AURORA_IF_PERF_CNT_EN defined -> if_valid=0 immediately; counters=0; refetch from RESET_PC; after 10 handshakes fetch_cnt=10.

Source files
------------

// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - shared core widths, reset vector and fetch entry type
package aurora_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/if_skid_fifo.sv
// rtl/if_skid_fifo.sv - two-entry fetch buffer with flush, count and head output
module if_skid_fifo
  import aurora_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = mem[rd_ptr];

  // Flush only rewinds pointers; stale storage is never visible because the
  // consumer qualifies the head with a non-zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, ROM request issue, response kill, decode buffer
// Optional performance counters are enabled by defining AURORA_IF_PERF_CNT_EN.
module if_stage
  import aurora_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             irom_en,
  output logic [XLEN-1:0]  irom_addr,
  input  logic [ILEN-1:0]  irom_rdata,
  output logic             if_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  if_pc,
  output logic [ILEN-1:0]  if_inst
`ifdef AURORA_IF_PERF_CNT_EN
  ,
  output logic [31:0]      if_perf_fetch_cnt,
  output logic [31:0]      if_perf_flush_cnt
`endif
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [1:0]      fifo_count;
  logic            handshake;
  logic            push;
  logic [2:0]      occupancy;
  logic [2:0]      limit;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign if_valid  = (fifo_count != 2'd0);
  assign handshake = if_valid & id_ready;

  // Reserve a slot for every outstanding request so a response always fits.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign limit     = 3'(FIFO_DEPTH) + {2'b00, handshake};
  assign irom_en   = !rst && !redirect && (occupancy < limit);
  assign irom_addr = pc;

  assign push           = inflight & !redirect;
  assign push_data.pc   = inflight_pc;
  assign push_data.inst = irom_rdata;

  assign if_pc   = if_valid ? head.pc   : '0;
  assign if_inst = if_valid ? head.inst : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc       <= align_word(redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= irom_en;
      if (irom_en) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
    end
  end

  if_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (handshake),
    .flush     (redirect),
    .push_data (push_data),
    .head      (head),
    .count     (fifo_count)
  );

`ifdef AURORA_IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_perf_fetch_cnt <= 32'd0;
      if_perf_flush_cnt <= 32'd0;
    end else begin
      if (handshake) if_perf_fetch_cnt <= if_perf_fetch_cnt + 32'd1;
      if (redirect)  if_perf_flush_cnt <= if_perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage: reset, stall, redirects, wrap, mid-stream reset
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irom_en;
  logic [31:0] irom_addr;
  logic [31:0] irom_rdata = 32'h0;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef AURORA_IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .irom_en     (irom_en),
    .irom_addr   (irom_addr),
    .irom_rdata  (irom_rdata),
    .if_valid    (if_valid),
    .id_ready    (id_ready),
    .if_pc       (if_pc),
    .if_inst     (if_inst)
`ifdef AURORA_IF_PERF_CNT_EN
    ,
    .if_perf_fetch_cnt (fetch_cnt),
    .if_perf_flush_cnt (flush_cnt)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (irom_en) irom_rdata <= rom_word(irom_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the next expected pc and its ROM word.
  always @(negedge clk) begin
    if (rst === 1'b0 && if_valid === 1'b1 && id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake actual_pc=%h required=none", if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e);
        check("sb_inst", if_inst, rom_word(e));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_irom_en", 32'(irom_en), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);

    // Reset release and streaming
    push_seq(32'h0, 12);
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    check("first_irom_en", 32'(irom_en), 32'd1);
    check("first_irom_addr", irom_addr, 32'h0);
    check("first_if_valid", 32'(if_valid), 32'd0);
    next_cycle(); @(negedge clk);
    check("r1_if_valid", 32'(if_valid), 32'd0);
    next_cycle(); @(negedge clk);
    check("r2_if_valid", 32'(if_valid), 32'd1);
    repeat (8) next_cycle();

    // Stall five cycles
    id_ready = 1'b0;
    @(negedge clk);
    check("stall_irom_en", 32'(irom_en), 32'd0);
    check("stall_pc", if_pc, 32'h20);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); @(negedge clk);
      check("stall_full_irom_en", 32'(irom_en), 32'd0);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_hold_pc", if_pc, 32'h20);
      check("stall_hold_inst", if_inst, rom_word(32'h20));
    end
    next_cycle(); id_ready = 1'b1;
    repeat (4) next_cycle();
    id_ready = 1'b0;
    next_cycle(); @(negedge clk);
    check("refill_irom_en", 32'(irom_en), 32'd0);
    check("refill_pc", if_pc, 32'h30);

    // Redirect while full, misaligned target
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
    push_seq(32'h100, 3);
    @(negedge clk);
    check("redir_suppress_en", 32'(irom_en), 32'd0);
    next_cycle(); redirect = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    check("redir_n1_en", 32'(irom_en), 32'd1);
    check("redir_n1_addr", irom_addr, 32'h100);
    check("redir_n1_valid", 32'(if_valid), 32'd0);
    next_cycle(); @(negedge clk);
    check("redir_n2_valid", 32'(if_valid), 32'd0);
    next_cycle(); @(negedge clk);
    check("redir_n3_valid", 32'(if_valid), 32'd1);
    check("redir_n3_pc", if_pc, 32'h100);
    repeat (3) next_cycle();

    // Resync to 0, then redirect concurrent with handshake of 0x8
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    push_seq(32'h0, 3);
    next_cycle(); redirect = 1'b0; id_ready = 1'b1;
    repeat (4) next_cycle();
    redirect = 1'b1; redirect_pc = 32'h200;
    push_seq(32'h200, 3);
    @(negedge clk);
    check("concur_pc", if_pc, 32'h8);
    next_cycle(); redirect = 1'b0;
    @(negedge clk);
    check("concur_no_dup", 32'(if_valid), 32'd0);
    next_cycle(); @(negedge clk);
    check("concur_n2_valid", 32'(if_valid), 32'd0);
    next_cycle(); @(negedge clk);
    check("concur_target_pc", if_pc, 32'h200);
    repeat (2) next_cycle();

    // Back-to-back redirects, last target wraps
    redirect = 1'b1; redirect_pc = 32'h300;
    exp_q.push_back(32'hFFFF_FFFC);
    push_seq(32'h0, 2);
    next_cycle(); redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    check("b2b_en", 32'(irom_en), 32'd0);
    check("b2b_valid", 32'(if_valid), 32'd0);
    next_cycle(); redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr0", irom_addr, 32'hFFFF_FFFC);
    next_cycle(); @(negedge clk);
    check("wrap_en", 32'(irom_en), 32'd1);
    check("wrap_addr1", irom_addr, 32'h0);
    repeat (4) next_cycle();
    id_ready = 1'b0;
    @(negedge clk);
    check("drain_a", 32'(exp_q.size()), 32'd0);
`ifdef AURORA_IF_PERF_CNT_EN
    check("perf_fetch_pre", fetch_cnt, 32'd24);
    check("perf_flush_pre", flush_cnt, 32'd5);
`endif

    // Asynchronous reset mid-stream
    repeat (2) next_cycle();
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(if_valid), 32'd0);
    check("arst_en", 32'(irom_en), 32'd0);
`ifdef AURORA_IF_PERF_CNT_EN
    check("arst_fetch_cnt", fetch_cnt, 32'd0);
    check("arst_flush_cnt", flush_cnt, 32'd0);
`endif
    push_seq(32'h0, 10);
    next_cycle();
    next_cycle(); rst = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    check("rerst_addr", irom_addr, 32'h0);
    check("rerst_en", 32'(irom_en), 32'd1);
    repeat (12) next_cycle();
    id_ready = 1'b0;
    @(negedge clk);
    check("drain_b", 32'(exp_q.size()), 32'd0);
`ifdef AURORA_IF_PERF_CNT_EN
    check("perf_fetch_10", fetch_cnt, 32'd10);
    check("perf_flush_0", flush_cnt, 32'd0);
`endif
    repeat (3) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
